// File: rtl/ibex_wb_queue.sv
// In-order writeback queue: holds up to DEPTH issued instructions, captures LSU responses and retires one per cycle.
// Optional macro IBEX_WB_PERF_EN adds per-entry perf_count/compressed/err fields and drives the retire counters.
module ibex_wb_queue #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_wb_i,
    input  logic [1:0]  instr_type_wb_i,
    input  logic [31:0] pc_id_i,
    input  logic        instr_is_compressed_id_i,
    input  logic        instr_perf_count_id_i,
    input  logic [4:0]  rf_waddr_id_i,
    input  logic [31:0] rf_wdata_id_i,
    input  logic        rf_we_id_i,
    input  logic [31:0] rf_wdata_lsu_i,
    input  logic        rf_we_lsu_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    input  logic [4:0]  rs_addr_a_i,
    input  logic [4:0]  rs_addr_b_i,
    output logic        ready_wb_o,
    output logic        hazard_a_o,
    output logic        hazard_b_o,
    output logic        outstanding_load_wb_o,
    output logic        outstanding_store_wb_o,
    output logic [4:0]  rf_waddr_wb_o,
    output logic [31:0] rf_wdata_wb_o,
    output logic        rf_we_wb_o,
    output logic [31:0] pc_wb_o,
    output logic        instr_done_wb_o,
    output logic        perf_instr_ret_wb_o,
    output logic        perf_instr_ret_compressed_wb_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        WB_LOAD  = 2'd0,
        WB_STORE = 2'd1,
        WB_OTHER = 2'd2
    } wb_type_e;

    logic [DEPTH-1:0] q_valid, q_done, q_we;
    wb_type_e         q_type  [DEPTH];
    logic [31:0]      q_pc    [DEPTH];
    logic [31:0]      q_wdata [DEPTH];
    logic [4:0]       q_waddr [DEPTH];

    logic [PW-1:0] head_q, tail_q, scan_idx, resp_idx;
    logic [PW:0]   count_q;
    logic          resp_found, resp_hit, head_bypass, retire, push;
    logic          head_we;
    logic [31:0]   head_wdata;

    // Oldest incomplete memory entry, scanning forward from the head.
    always_comb begin
        resp_found = 1'b0;
        resp_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + i[PW-1:0];
            if (!resp_found && q_valid[scan_idx] && (q_type[scan_idx] != WB_OTHER) && !q_done[scan_idx]) begin
                resp_found = 1'b1;
                resp_idx   = scan_idx;
            end
        end
    end

    assign resp_hit    = lsu_resp_valid_i & resp_found;
    assign head_bypass = resp_hit & (resp_idx == head_q);
    assign retire      = q_valid[head_q] & (q_done[head_q] | head_bypass);
    assign ready_wb_o  = (count_q < (PW+1)'(DEPTH)) | retire;
    assign push        = en_wb_i & ready_wb_o;

    assign head_wdata = (head_bypass && q_type[head_q] == WB_LOAD) ? rf_wdata_lsu_i : q_wdata[head_q];
    assign head_we    = (head_bypass && q_type[head_q] == WB_LOAD) ? rf_we_lsu_i    : q_we[head_q];

    assign instr_done_wb_o = retire;
    assign rf_we_wb_o      = retire & head_we;
    assign rf_waddr_wb_o   = q_waddr[head_q];
    assign rf_wdata_wb_o   = head_wdata;
    assign pc_wb_o         = q_pc[head_q];

    always_comb begin
        hazard_a_o             = 1'b0;
        hazard_b_o             = 1'b0;
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_we[i] || q_type[i] == WB_LOAD)) begin
                if (q_waddr[i] == rs_addr_a_i && rs_addr_a_i != 5'd0) hazard_a_o = 1'b1;
                if (q_waddr[i] == rs_addr_b_i && rs_addr_b_i != 5'd0) hazard_b_o = 1'b1;
            end
            if (q_valid[i] && !q_done[i] && q_type[i] == WB_LOAD)  outstanding_load_wb_o  = 1'b1;
            if (q_valid[i] && !q_done[i] && q_type[i] == WB_STORE) outstanding_store_wb_o = 1'b1;
        end
    end

    // Push is applied last so a slot freed by retire and refilled the same cycle takes the new entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            q_valid <= '0;
            q_done  <= '0;
            q_we    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_type[i]  <= WB_LOAD;
                q_pc[i]    <= '0;
                q_wdata[i] <= '0;
                q_waddr[i] <= '0;
            end
        end else begin
            if (resp_hit) begin
                q_done[resp_idx] <= 1'b1;
                if (q_type[resp_idx] == WB_LOAD) begin
                    q_wdata[resp_idx] <= rf_wdata_lsu_i;
                    q_we[resp_idx]    <= rf_we_lsu_i;
                end
            end
            if (retire) begin
                q_valid[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                q_valid[tail_q] <= 1'b1;
                q_type[tail_q]  <= wb_type_e'(instr_type_wb_i);
                q_pc[tail_q]    <= pc_id_i;
                q_waddr[tail_q] <= rf_waddr_id_i;
                q_wdata[tail_q] <= rf_wdata_id_i;
                q_we[tail_q]    <= rf_we_id_i;
                q_done[tail_q]  <= (instr_type_wb_i == WB_OTHER);
                tail_q          <= tail_q + 1'b1;
            end
            if (push && !retire) begin
                count_q <= count_q + 1'b1;
            end else if (!push && retire) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifdef IBEX_WB_PERF_EN
    logic [DEPTH-1:0] q_perf, q_comp, q_err;
    logic             head_err;

    assign head_err                       = head_bypass ? lsu_resp_err_i : q_err[head_q];
    assign perf_instr_ret_wb_o            = retire & q_perf[head_q] & ~head_err;
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & q_comp[head_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_perf <= '0;
            q_comp <= '0;
            q_err  <= '0;
        end else begin
            if (resp_hit) begin
                q_err[resp_idx] <= lsu_resp_err_i;
            end
            if (push) begin
                q_perf[tail_q] <= instr_perf_count_id_i;
                q_comp[tail_q] <= instr_is_compressed_id_i;
                q_err[tail_q]  <= 1'b0;
            end
        end
    end
`else
    logic unused_perf_inputs;
    assign unused_perf_inputs             = ^{instr_is_compressed_id_i, instr_perf_count_id_i, lsu_resp_err_i};
    assign perf_instr_ret_wb_o            = 1'b0;
    assign perf_instr_ret_compressed_wb_o = 1'b0;
`endif

`ifndef SYNTHESIS
    resp_has_target : assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_resp_valid_i |-> resp_found);
`endif

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Directed bench for ibex_wb_queue (DEPTH=2): retire contents go through a scoreboard, status signals are checked per cycle.
module tb_ibex_wb_queue;

    localparam logic [1:0] T_LOAD  = 2'd0;
    localparam logic [1:0] T_STORE = 2'd1;
    localparam logic [1:0] T_OTHER = 2'd2;
`ifdef IBEX_WB_PERF_EN
    localparam bit PON = 1'b1;
`else
    localparam bit PON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_wb_i;
    logic [1:0]  instr_type_wb_i;
    logic [31:0] pc_id_i;
    logic        instr_is_compressed_id_i;
    logic        instr_perf_count_id_i;
    logic [4:0]  rf_waddr_id_i;
    logic [31:0] rf_wdata_id_i;
    logic        rf_we_id_i;
    logic [31:0] rf_wdata_lsu_i;
    logic        rf_we_lsu_i;
    logic        lsu_resp_valid_i;
    logic        lsu_resp_err_i;
    logic [4:0]  rs_addr_a_i;
    logic [4:0]  rs_addr_b_i;
    logic        ready_wb_o;
    logic        hazard_a_o;
    logic        hazard_b_o;
    logic        outstanding_load_wb_o;
    logic        outstanding_store_wb_o;
    logic [4:0]  rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o;
    logic        rf_we_wb_o;
    logic [31:0] pc_wb_o;
    logic        instr_done_wb_o;
    logic        perf_instr_ret_wb_o;
    logic        perf_instr_ret_compressed_wb_o;

    ibex_wb_queue #(.DEPTH(2)) dut (
        .clk_i                          (clk_i),
        .rst_ni                         (rst_ni),
        .en_wb_i                        (en_wb_i),
        .instr_type_wb_i                (instr_type_wb_i),
        .pc_id_i                        (pc_id_i),
        .instr_is_compressed_id_i       (instr_is_compressed_id_i),
        .instr_perf_count_id_i          (instr_perf_count_id_i),
        .rf_waddr_id_i                  (rf_waddr_id_i),
        .rf_wdata_id_i                  (rf_wdata_id_i),
        .rf_we_id_i                     (rf_we_id_i),
        .rf_wdata_lsu_i                 (rf_wdata_lsu_i),
        .rf_we_lsu_i                    (rf_we_lsu_i),
        .lsu_resp_valid_i               (lsu_resp_valid_i),
        .lsu_resp_err_i                 (lsu_resp_err_i),
        .rs_addr_a_i                    (rs_addr_a_i),
        .rs_addr_b_i                    (rs_addr_b_i),
        .ready_wb_o                     (ready_wb_o),
        .hazard_a_o                     (hazard_a_o),
        .hazard_b_o                     (hazard_b_o),
        .outstanding_load_wb_o          (outstanding_load_wb_o),
        .outstanding_store_wb_o         (outstanding_store_wb_o),
        .rf_waddr_wb_o                  (rf_waddr_wb_o),
        .rf_wdata_wb_o                  (rf_wdata_wb_o),
        .rf_we_wb_o                     (rf_we_wb_o),
        .pc_wb_o                        (pc_wb_o),
        .instr_done_wb_o                (instr_done_wb_o),
        .perf_instr_ret_wb_o            (perf_instr_ret_wb_o),
        .perf_instr_ret_compressed_wb_o (perf_instr_ret_compressed_wb_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic        perf;
        logic        perfc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   check_count = 0;
    int   pass_count  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic expectRetire(input logic [4:0] waddr, input logic [31:0] wdata, input logic we,
                                input logic perf, input logic perfc);
        exp_t e;
        e.waddr = waddr;
        e.wdata = wdata;
        e.we    = we;
        e.perf  = perf & PON;
        e.perfc = perfc & PON;
        sb.push_back(e);
    endtask

    task automatic clearInputs();
        en_wb_i                  = 1'b0;
        instr_type_wb_i          = T_OTHER;
        pc_id_i                  = '0;
        instr_is_compressed_id_i = 1'b0;
        instr_perf_count_id_i    = 1'b0;
        rf_waddr_id_i            = '0;
        rf_wdata_id_i            = '0;
        rf_we_id_i               = 1'b0;
        lsu_resp_valid_i         = 1'b0;
        rf_wdata_lsu_i           = '0;
        rf_we_lsu_i              = 1'b0;
        lsu_resp_err_i           = 1'b0;
    endtask

    task automatic applyStimulus(input logic push, input logic [1:0] typ, input logic [4:0] waddr,
                                 input logic [31:0] wdata, input logic we, input logic [31:0] pc,
                                 input logic comp, input logic perf, input logic resp,
                                 input logic [31:0] ldata, input logic lwe, input logic lerr);
        en_wb_i                  = push;
        instr_type_wb_i          = typ;
        rf_waddr_id_i            = waddr;
        rf_wdata_id_i            = wdata;
        rf_we_id_i               = we;
        pc_id_i                  = pc;
        instr_is_compressed_id_i = comp;
        instr_perf_count_id_i    = perf;
        lsu_resp_valid_i         = resp;
        rf_wdata_lsu_i           = ldata;
        rf_we_lsu_i              = lwe;
        lsu_resp_err_i           = lerr;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic endCycle();
        @(posedge clk_i);
        #1;
        clearInputs();
    endtask

    // Scoreboard monitor: every retirement must match the oldest expected entry
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && instr_done_wb_o === 1'b1) begin
            if (sb.size() == 0) begin
                check_count++;
                $display("[TB] FAIL unexpected_retire: pc 0x%08h retired, expected no retire at %0t", pc_wb_o, $time);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("retire_we", rf_we_wb_o, mon_e.we);
                if (mon_e.we) begin
                    checkOutput("retire_waddr", rf_waddr_wb_o, mon_e.waddr);
                    checkOutput("retire_wdata", rf_wdata_wb_o, mon_e.wdata);
                end
                checkOutput("retire_perf", perf_instr_ret_wb_o, mon_e.perf);
                checkOutput("retire_perf_c", perf_instr_ret_compressed_wb_o, mon_e.perfc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        rst_ni      = 1'b0;
        rs_addr_a_i = 5'd5;
        rs_addr_b_i = 5'd3;

        // Reset state
        sample();
        checkOutput("rst_ready", ready_wb_o, 1);
        checkOutput("rst_done", instr_done_wb_o, 0);
        checkOutput("rst_we", rf_we_wb_o, 0);
        checkOutput("rst_haz_a", hazard_a_o, 0);
        checkOutput("rst_haz_b", hazard_b_o, 0);
        checkOutput("rst_out_load", outstanding_load_wb_o, 0);
        checkOutput("rst_out_store", outstanding_store_wb_o, 0);
        checkOutput("rst_pc", pc_wb_o, 0);
        checkOutput("rst_waddr", rf_waddr_wb_o, 0);
        checkOutput("rst_wdata", rf_wdata_wb_o, 0);
        checkOutput("rst_perf", perf_instr_ret_wb_o, 0);
        checkOutput("rst_perf_c", perf_instr_ret_compressed_wb_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Single OTHER into an empty queue retires the next cycle
        applyStimulus(1, T_OTHER, 5'd5, 32'hA5A5_0001, 1, 32'h100, 0, 1, 0, 0, 0, 0);
        expectRetire(5'd5, 32'hA5A5_0001, 1, 1, 0);
        sample();
        checkOutput("t1_no_early_retire", instr_done_wb_o, 0);
        checkOutput("t1_ready_push", ready_wb_o, 1);
        endCycle();
        sample();
        checkOutput("t1_retire", instr_done_wb_o, 1);
        checkOutput("t1_ready", ready_wb_o, 1);
        checkOutput("t1_pc", pc_wb_o, 32'h100);
        endCycle();
        sample();
        checkOutput("t1_idle", instr_done_wb_o, 0);
        endCycle();

        // LOAD blocks a younger OTHER until its response arrives
        applyStimulus(1, T_LOAD, 5'd3, 32'h0, 0, 32'h104, 0, 1, 0, 0, 0, 0);
        expectRetire(5'd3, 32'h0000_1234, 1, 1, 0);
        endCycle();
        rs_addr_a_i = 5'd4;
        rs_addr_b_i = 5'd3;
        applyStimulus(1, T_OTHER, 5'd4, 32'h44, 1, 32'h108, 1, 1, 0, 0, 0, 0);
        expectRetire(5'd4, 32'h44, 1, 1, 1);
        sample();
        checkOutput("t2_ready_one", ready_wb_o, 1);
        endCycle();
        for (int i = 0; i < 3; i++) begin
            sample();
            checkOutput("t2_wait_done", instr_done_wb_o, 0);
            checkOutput("t2_wait_ready", ready_wb_o, 0);
            checkOutput("t2_haz_a", hazard_a_o, 1);
            checkOutput("t2_haz_b_load", hazard_b_o, 1);
            checkOutput("t2_out_load", outstanding_load_wb_o, 1);
            endCycle();
        end
        applyStimulus(0, T_OTHER, 0, 0, 0, 0, 0, 0, 1, 32'h0000_1234, 1, 0);
        sample();
        checkOutput("t2_bypass_done", instr_done_wb_o, 1);
        checkOutput("t2_bypass_ready", ready_wb_o, 1);
        checkOutput("t2_bypass_pc", pc_wb_o, 32'h104);
        endCycle();
        sample();
        checkOutput("t2_other_done", instr_done_wb_o, 1);
        checkOutput("t2_out_load_clr", outstanding_load_wb_o, 0);
        checkOutput("t2_haz_b_clr", hazard_b_o, 0);
        checkOutput("t2_haz_a_retiring", hazard_a_o, 1);
        endCycle();
        sample();
        checkOutput("t2_empty_done", instr_done_wb_o, 0);
        checkOutput("t2_empty_haz", hazard_a_o, 0);
        endCycle();

        // Fill with STORE+OTHER, push while full and retiring, capture load data behind a head OTHER
        applyStimulus(1, T_STORE, 5'd9, 32'h0, 0, 32'h200, 1, 1, 0, 0, 0, 0);
        expectRetire(5'd9, 32'h0, 0, 1, 1);
        endCycle();
        rs_addr_b_i = 5'd7;
        applyStimulus(1, T_OTHER, 5'd7, 32'h77, 1, 32'h204, 0, 1, 0, 0, 0, 0);
        expectRetire(5'd7, 32'h77, 1, 1, 0);
        sample();
        checkOutput("t3_ready_one", ready_wb_o, 1);
        endCycle();
        applyStimulus(1, T_OTHER, 5'd31, 32'hBAD, 1, 32'hBAD, 0, 1, 0, 0, 0, 0);
        sample();
        checkOutput("t3_full_ready", ready_wb_o, 0);
        checkOutput("t3_full_done", instr_done_wb_o, 0);
        checkOutput("t3_out_store", outstanding_store_wb_o, 1);
        checkOutput("t3_haz_b", hazard_b_o, 1);
        endCycle();
        applyStimulus(1, T_LOAD, 5'd0, 32'h0, 0, 32'h208, 0, 1, 1, 32'h0, 0, 0);
        expectRetire(5'd0, 32'h0000_BEEF, 1, 1, 0);
        sample();
        checkOutput("t3_full_retire", instr_done_wb_o, 1);
        checkOutput("t3_full_ready_via_done", ready_wb_o, 1);
        checkOutput("t3_store_pc", pc_wb_o, 32'h200);
        endCycle();
        rs_addr_a_i = 5'd0;
        applyStimulus(0, T_OTHER, 0, 0, 0, 0, 0, 0, 1, 32'h0000_BEEF, 1, 0);
        sample();
        checkOutput("t3_other_done", instr_done_wb_o, 1);
        checkOutput("t3_other_pc", pc_wb_o, 32'h204);
        checkOutput("t3_ready_count2", ready_wb_o, 1);
        checkOutput("t3_haz_x0", hazard_a_o, 0);
        checkOutput("t3_out_load", outstanding_load_wb_o, 1);
        endCycle();
        sample();
        checkOutput("t3_load_done", instr_done_wb_o, 1);
        checkOutput("t3_load_pc", pc_wb_o, 32'h208);
        checkOutput("t3_out_load_clr", outstanding_load_wb_o, 0);
        endCycle();

        // Load with bus error: no write, not counted
        applyStimulus(1, T_LOAD, 5'd6, 32'h0, 0, 32'h300, 1, 1, 0, 0, 0, 0);
        expectRetire(5'd6, 32'h0, 0, 0, 0);
        endCycle();
        applyStimulus(0, T_OTHER, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD, 0, 1);
        sample();
        checkOutput("t5_err_done", instr_done_wb_o, 1);
        checkOutput("t5_err_we", rf_we_wb_o, 0);
        checkOutput("t5_err_perf", perf_instr_ret_wb_o, 0);
        endCycle();

        // Asynchronous reset with two entries pending
        rs_addr_a_i = 5'd8;
        applyStimulus(1, T_LOAD, 5'd8, 32'h0, 0, 32'h400, 0, 1, 0, 0, 0, 0);
        endCycle();
        applyStimulus(1, T_LOAD, 5'd9, 32'h0, 0, 32'h404, 0, 1, 0, 0, 0, 0);
        endCycle();
        sample();
        checkOutput("t6_pre_ready", ready_wb_o, 0);
        checkOutput("t6_pre_haz", hazard_a_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("t6_rst_ready", ready_wb_o, 1);
        checkOutput("t6_rst_done", instr_done_wb_o, 0);
        checkOutput("t6_rst_haz", hazard_a_o, 0);
        checkOutput("t6_rst_out_load", outstanding_load_wb_o, 0);
        checkOutput("t6_rst_pc", pc_wb_o, 0);
        checkOutput("t6_rst_we", rf_we_wb_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        applyStimulus(1, T_OTHER, 5'd10, 32'h0000_AAAA, 1, 32'h500, 0, 1, 0, 0, 0, 0);
        expectRetire(5'd10, 32'h0000_AAAA, 1, 1, 0);
        sample();
        checkOutput("t6_post_no_early", instr_done_wb_o, 0);
        endCycle();
        sample();
        checkOutput("t6_post_done", instr_done_wb_o, 1);
        checkOutput("t6_post_we", rf_we_wb_o, 1);
        checkOutput("t6_post_ready", ready_wb_o, 1);
        endCycle();

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            sample();
        end
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
